// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Byte-stream instruction memory loader. Assembles little-endian
//            32-bit words from a valid/ready byte stream and writes them to
//            the instruction memory. cpu_rst stays high until a clean image
//            has been loaded. Optional trailer checksum: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_written,
    output logic             cpu_rst
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd5;
    localparam logic [2:0] c_end_state = S_CHK;
`else
    localparam logic [2:0] c_end_state = S_DONE;
`endif
    localparam logic [31:0] c_depth = 32'(DEPTH);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_ready;
    logic             w_ready_nxt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_shift;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_word_idx;
    logic [1:0]       r_byte_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       r_chk;
`endif

    logic             w_xfer;
    logic [CNT_W-1:0] w_len;
    logic             w_in_range;
    logic             w_last_word;

    assign w_xfer      = s_valid & r_ready;
    assign w_len       = CNT_W'({s_data, r_len[7:0]});
    assign w_in_range  = (32'(r_word_idx) < c_depth);
    assign w_last_word = ((r_word_idx + CNT_W'(1)) == r_len);

    assign s_ready       = r_ready;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign words_written = r_cnt;
    assign cpu_rst       = ~((r_state == S_DONE) & ~r_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ready_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_LEN0;
            S_LEN0:  if (w_xfer) w_next = S_LEN1;
            S_LEN1:  if (w_xfer) w_next = (w_len == '0) ? c_end_state : S_DATA;
            S_DATA:  if (w_xfer && (r_byte_idx == 2'd3)) w_next = S_WRITE;
            S_WRITE: w_next = w_last_word ? c_end_state : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:   if (w_xfer) w_next = S_DONE;
`endif
            default: w_next = S_IDLE;
        endcase
        // s_ready is registered, so it is decoded from the state being entered
        case (w_next)
            S_LEN0, S_LEN1, S_DATA: w_ready_nxt = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                  w_ready_nxt = 1'b1;
`endif
            default:                w_ready_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk      <= '0;
`endif
        end else begin
            r_ready <= w_ready_nxt;
            r_we    <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_cnt      <= '0;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_chk      <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (w_xfer) r_len <= CNT_W'(s_data);
                end
                S_LEN1: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        // oversize image: keep consuming, but never wrap
                        if (32'(w_len) > c_depth) r_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_shift    <= {s_data, r_shift[31:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_we <= w_in_range;
                            if (w_in_range) begin
                                r_addr  <= BASE_ADDR + (32'(r_word_idx) << 2);
                                r_wdata <= {s_data, r_shift[31:8]};
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_cnt      <= r_cnt + {{(CNT_W-1){1'b0}}, r_we};
                    r_word_idx <= r_word_idx + CNT_W'(1);
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_xfer && (s_data != r_chk)) r_err <= 1'b1;
                end
`endif
                default: ;
            endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_xfer && (r_state != S_CHK)) r_chk <= r_chk ^ s_data;
`endif
            if ((w_next == S_DONE) && (r_state != S_DONE)) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed bench for imem_loader; DEPTH=1024 and DEPTH=4 instances
//            share one byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;

    logic        ready0, we0, busy0, done0, err0, cpu0;
    logic [31:0] addr0, wdata0;
    logic [15:0] ww0;
    logic        ready4, we4, busy4, done4, err4, cpu4;
    logic [31:0] addr4, wdata4;
    logic [15:0] ww4;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(ready0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .busy(busy0), .done(done0), .err(err0), .words_written(ww0), .cpu_rst(cpu0)
    );

    imem_loader #(.DEPTH(4), .BASE_ADDR(32'h0), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(ready4), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
        .busy(busy4), .done(done4), .err(err4), .words_written(ww4), .cpu_rst(cpu4)
    );

    int          n_vec  = 0;
    int          n_bad  = 0;
    int          n_viol = 0;
    logic [31:0] q_addr0[$];
    logic [31:0] q_data0[$];
    logic [31:0] q_addr4[$];
    logic [31:0] q_data4[$];
    logic [7:0]  img[$];

    always @(negedge clk) begin
        if (we0) begin
            q_addr0.push_back(addr0);
            q_data0.push_back(wdata0);
            if (ready0) n_viol++;
        end
        if (we4) begin
            q_addr4.push_back(addr4);
            q_data4.push_back(wdata4);
            if (ready4) n_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_addr0.delete(); q_data0.delete();
        q_addr4.delete(); q_data4.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!ready0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", 32'(ready0), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_img(input int gap, input int start_at);
        for (int i = 0; i < img.size(); i++) begin
            if (i == start_at) pulse_start();
            send(img[i], gap);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("done0", 32'(done0), 32'd1);
    endtask

    task automatic set_img1();
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h02, 8'h62, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(8'h67);
`endif
    endtask

    task automatic check_img1(input string tag);
        check({tag, "_nwr"},   32'(q_addr0.size()), 32'd2);
        if (q_addr0.size() == 2) begin
            check({tag, "_a0"}, q_addr0[0], 32'h0000_0000);
            check({tag, "_d0"}, q_data0[0], 32'h00A0_0513);
            check({tag, "_a1"}, q_addr0[1], 32'h0000_0004);
            check({tag, "_d1"}, q_data0[1], 32'h0062_02B3);
        end
        check({tag, "_nwr4"},  32'(q_addr4.size()), 32'd2);
        check({tag, "_err"},   32'(err0), 32'd0);
        check({tag, "_cpu"},   32'(cpu0), 32'd0);
        check({tag, "_busy"},  32'(busy0), 32'd0);
        check({tag, "_ww"},    32'(ww0), 32'd2);
        check({tag, "_ww4"},   32'(ww4), 32'd2);
        check({tag, "_done4"}, 32'(done4), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready0), 32'd0);
        check("rst_busy",  32'(busy0),  32'd0);
        check("rst_done",  32'(done0),  32'd0);
        check("rst_err",   32'(err0),   32'd0);
        check("rst_cpu",   32'(cpu0),   32'd1);
        check("rst_we",    32'(we0),    32'd0);
        check("rst_addr",  addr0,       32'd0);
        check("rst_wdata", wdata0,      32'd0);
        check("rst_ww",    32'(ww0),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic two-word image
        clear_log();
        set_img1();
        pulse_start();
        check("t1_busy", 32'(busy0), 32'd1);
        send_img(0, -1);
        wait_done();
        check_img1("t1");

        // empty image
        clear_log();
        img = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(8'h00);
`endif
        pulse_start();
        check("t2_clr_ww", 32'(ww0), 32'd0);
        send_img(0, -1);
        wait_done();
        check("t2_nwr",  32'(q_addr0.size() + q_addr4.size()), 32'd0);
        check("t2_cpu",  32'(cpu0), 32'd0);
        check("t2_err",  32'(err0), 32'd0);
        check("t2_ww",   32'(ww0),  32'd0);

        // five words into DEPTH=4: last one dropped, err raised
        clear_log();
        img = '{8'h05, 8'h00};
        for (int i = 0; i < 20; i++) img.push_back(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(8'h05);
`endif
        pulse_start();
        send_img(0, -1);
        wait_done();
        check("t3_done4", 32'(done4), 32'd1);
        check("t3_nwr4",  32'(q_addr4.size()), 32'd4);
        if (q_addr4.size() == 4) begin
            check("t3_a3", q_addr4[3], 32'h0000_000C);
            check("t3_d3", q_data4[3], 32'h0F0E_0D0C);
            check("t3_d0", q_data4[0], 32'h0302_0100);
        end
        check("t3_err4",  32'(err4),  32'd1);
        check("t3_cpu4",  32'(cpu4),  32'd1);
        check("t3_ww4",   32'(ww4),   32'd4);
        check("t3_rdy4",  32'(ready4), 32'd0);
        check("t3_ww0",   32'(ww0),   32'd5);
        check("t3_err0",  32'(err0),  32'd0);
        check("t3_last0", wdata0,     32'h1312_1110);

        // throttled source plus a stray start mid-load
        clear_log();
        set_img1();
        pulse_start();
        send_img(1, 5);
        wait_done();
        check_img1("t4");
        check("t4_rdy_we", 32'(n_viol), 32'd0);

        // reset after the first of three words
        clear_log();
        img = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start();
        send_img(0, -1);
        @(negedge clk);
        check("t5_nwr", 32'(q_addr0.size()), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_busy",  32'(busy0),  32'd0);
        check("t5_cpu",   32'(cpu0),   32'd1);
        check("t5_ready", 32'(ready0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        set_img1();
        pulse_start();
        send_img(0, -1);
        wait_done();
        check_img1("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
        clear_log();
        img = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
        pulse_start();
        send_img(0, -1);
        wait_done();
        check("t6_err_ok", 32'(err0), 32'd0);
        check("t6_cpu_ok", 32'(cpu0), 32'd0);
        img = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00};
        pulse_start();
        send_img(0, -1);
        wait_done();
        check("t6_err_bad", 32'(err0), 32'd1);
        check("t6_cpu_bad", 32'(cpu0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles 32-bit little-endian instruction words, and drives the memory write port at word-aligned byte addresses.
- Holds the processor in reset (cpu_rst) until a complete, error-free image has been written.

Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words; writes past this are suppressed.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be a multiple of 4.
- CNT_W, 16, width of the header word count and of words_written.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- s_valid  input  1  byte-stream valid.
- s_data  input  8  byte-stream data.
- s_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address; bits [1:0] always 0.
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  load finished; held until the next start.
- err  output  1  load failed; held until the next start.
- words_written  output  CNT_W  count of words actually written to memory.
- cpu_rst  output  1  processor reset; high except in DONE with err=0.

Behaviour:
- Reset (async, rst=1): state=IDLE, cpu_rst=1; s_ready, mem_we, busy, done, err = 0; words_written, mem_addr, mem_wdata, byte index and word index = 0.
- Handshake: a byte transfers on a rising edge with s_valid&s_ready. s_ready is registered: 1 only in LEN0, LEN1, DATA and CHK (when the optional feature is enabled), 0 in every other state.
- State machine:
  - IDLE: on start -> LEN0; set busy=1 and clear done, err, words_written.
  - LEN0: accept byte -> N[7:0]; go to LEN1.
  - LEN1: accept byte -> N[15:8].
    - N=0 -> DONE (or CHK if enabled).
    - N>DEPTH -> set err=1 and go to DATA.
    - Otherwise -> DATA.
  - DATA: accept bytes into the word shift register, little-endian (first byte -> bits [7:0]). On the 4th byte go to WRITE.
  - WRITE (exactly 1 cycle):
    - mem_we=1, mem_addr=BASE_ADDR+4*word_idx, mem_wdata=assembled word.
    - If word_idx>=DEPTH, mem_we=0 (word dropped), but the word is still counted toward N.
    - words_written increments only when mem_we=1.
    - Then word_idx+1: if it equals N -> DONE (or CHK), else -> DATA.
  - DONE: busy=0, done=1, cpu_rst=err. On start -> LEN0 with the same clears as from IDLE.
- Throughput: at most 1 byte per cycle; 1 bubble cycle (WRITE) per word, so a word costs 5 cycles minimum.
- start is ignored while busy=1.
- s_valid with s_ready=0: the byte is not consumed; the source must hold it.
- Addressing: mem_addr is a byte address, incremented by 4 per word, so memory word index = mem_addr[31:2]. No wrap-around: an N above DEPTH is flagged via err, never wrapped.
- Reset mid-load: immediate return to IDLE with cpu_rst=1. Words already written remain in memory; no rollback.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - A CHK state follows the last word (or LEN1 when N=0) and accepts one byte.
  - Expected value is the running XOR of both header bytes and all 4N payload bytes.
  - On mismatch, err=1. Then -> DONE.
- Disabled:
  - No CHK state; no trailing byte is consumed.
  - err is set only by N>DEPTH.

Test Plan:
- Reset then start; stream 02 00 13 05 A0 00 B3 02 62 00 -> writes addr 0x0 = 0x00A00513 and addr 0x4 = 0x006202B3; done=1, err=0, cpu_rst=0, words_written=2.
- Header 00 00 -> DONE right after LEN1 with no mem_we pulses; done=1, cpu_rst=0 (with checksum enabled, trailer byte 00 is required).
- DEPTH=4, header 05 00 plus 20 bytes -> 4 writes at 0x0..0xC, 5th word dropped; err=1, cpu_rst=1, words_written=4, all 22 bytes consumed.
- s_valid toggled every other cycle, and a start pulse mid-load -> identical memory contents; start ignored; s_ready=0 during each WRITE cycle.
- Assert rst after 1 of 3 words -> next cycle state=IDLE, busy=0, cpu_rst=1; a new start followed by a full image completes normally.
- IMEM_LOADER_CHECKSUM_EN: image 01 00 13 05 A0 00 with trailer 0xB7 -> err=0. Same image with trailer 0x00 -> err=1, cpu_rst=1.
